fanout_fork_ctrl: RTL and testbench
===================================

# fanout_fork_ctrl

Registered handshake controller for one producer feeding up to NUM_OUT consumers through an eager fork. It holds the per-branch enable and select configuration in shadow registers and computes the active-branch mask from them. It tracks which branches have already taken the current token and returns upstream ready only when every active branch has been served. It also keeps token and stall counters for the interconnect debug path.

## Interface
Parameters:
- NUM_OUT, 20, number of fanout branches
- SEL_W, 8, width of each per-branch select field
- SEL_BIT, 6, bit of the select field that marks a branch as routed to this fork
- CNT_W, 16, width of the token and stall counters

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- cfg_load  in  1  one-cycle request to load a new configuration
- cfg_en  in  NUM_OUT  per-branch enable, sampled with cfg_load
- cfg_sel  in  NUM_OUT*SEL_W  per-branch select fields; branch i uses bits [i*SEL_W +: SEL_W]
- cfg_busy  out  1  a configuration load is pending
- in_valid  in  1  producer token valid
- in_ready  out  1  token accepted by all active branches
- out_valid  out  NUM_OUT  per-branch valid
- out_ready  in  NUM_OUT  per-branch ready
- tok_cnt  out  CNT_W  tokens accepted; wraps at the top of its range
- stall_cnt  out  CNT_W  cycles with in_valid & ~in_ready; saturates at all-ones
- cnt_clr  in  1  synchronous clear of both counters

## Operation
- Active mask: active[i] = en_q[i] & sel_q[i][SEL_BIT].
- Taken vector taken[NUM_OUT] records the branches that have already accepted the current token.
- out_valid[i] = in_valid & active[i] & ~taken[i]. This is combinational from the registers and in_valid.
- in_ready = AND over i of (~active[i] | taken[i] | out_ready[i]). It is combinational.
- With no active branch, in_ready = 1 and tokens are consumed and dropped. tok_cnt still increments in this case.
- Accept occurs when in_valid & in_ready. On accept, taken clears to 0 and tok_cnt increments.
- Otherwise, taken[i] |= out_valid[i] & out_ready[i].
- FSM state IDLE: taken == 0.
  - Partial delivery without accept: go to PARTIAL.
  - cfg_load: load en_q and sel_q at the clock edge and stay in IDLE.
- FSM state PARTIAL: taken != 0.
  - Accept: go to IDLE.
  - cfg_load: capture the new configuration into pend_en and pend_sel, set cfg_busy, go to CFG_WAIT.
- FSM state CFG_WAIT: the old configuration stays in use.
  - On accept: copy the pending configuration into en_q and sel_q, clear cfg_busy, go to IDLE.
  - A second cfg_load overwrites the pending configuration. The last load wins.
- Counters:
  - stall_cnt increments on in_valid & ~in_ready and saturates.
  - cnt_clr has priority over any increment in the same cycle.
- Same-cycle events:
  - Accept plus cfg_load in IDLE: the token is accepted under the old configuration, and the new configuration applies from the next cycle.
  - Accept plus cfg_load in PARTIAL: the token completes under the old configuration, and the new configuration is applied directly to en_q and sel_q. The FSM goes to IDLE and cfg_busy stays 0.
- Dropping in_valid while in PARTIAL is a protocol violation. The taken bits are held, and the bench asserts against it.

## Timing
- Reset values (rst_n low at the edge):
  - en_q = 0, sel_q = 0, taken = 0, pending configuration = 0
  - FSM = IDLE, cfg_busy = 0, tok_cnt = 0, stall_cnt = 0
  - resulting outputs: out_valid = 0, in_ready = 1
- Reset in the middle of a token discards the partial delivery. The next token is delivered to all active branches again.
- Handshake latency is zero cycles. A token with all active branches ready is accepted in the same cycle.
- Each branch sees exactly one out_valid & out_ready per token.
- The configuration takes effect one cycle after its load edge.

## Structure
- Package fanout_pkg holds:
  - the state enum {IDLE, PARTIAL, CFG_WAIT}
  - the parameter defaults
  - the function sel_active(en, sel) returning the active mask
- One sub-module, fanout_branch, holds the per-branch taken flop and the out_valid/ready term. It is instantiated NUM_OUT times. The FSM, configuration registers and counters live in the top level.

## Test plan
- Reset, then cfg_load with cfg_en = 0x00003 and bit 6 set in S0 and S1; in_valid = 1, all out_ready = 1 -> out_valid = 0x00003, in_ready = 1 in the same cycle, tok_cnt = 1.
- Same configuration; out_ready[0] = 1 for one cycle while out_ready[1] = 0, then out_ready[1] = 1 -> branch 0 is served once and deasserts its valid, in_ready rises in cycle 2, stall_cnt = 1.
- cfg_en = 0x00001 but S0[6] = 0 -> active = 0, in_ready = 1, out_valid = 0, tokens counted and dropped.
- cfg_load of branch 2 while in PARTIAL -> cfg_busy = 1 and branch 2 gets no valid for the current token. After accept, cfg_busy = 0 and the next token drives out_valid[2].
- Hold in_valid with out_ready = 0 for 70000 cycles -> stall_cnt saturates at 0xFFFF. cnt_clr -> both counters read 0 the next cycle.
- rst_n low for one cycle during PARTIAL -> all outputs at their reset values, and the previously served branches receive the next token again.

Source files
------------

// File: rtl/fanout_pkg.sv
// rtl/fanout_pkg.sv - shared types, defaults and helpers for the fanout fork controller
package fanout_pkg;

    localparam int NUM_OUT_DEF = 20;
    localparam int SEL_W_DEF   = 8;
    localparam int SEL_BIT_DEF = 6;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PARTIAL  = 2'd1,
        CFG_WAIT = 2'd2
    } state_t;

    // A branch participates only when enabled and routed to this fork.
    function automatic logic sel_active(input logic en, input logic sel_bit);
        return en & sel_bit;
    endfunction

endpackage

// File: rtl/fanout_branch.sv
// rtl/fanout_branch.sv - per-branch taken flag and valid/ready terms of the eager fork
module fanout_branch
(
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    input  logic active,
    input  logic out_ready,
    input  logic accept,
    output logic out_valid,
    output logic served,
    output logic ready_term
);

    logic taken;

    assign out_valid  = in_valid & active & ~taken;
    assign served     = out_valid & out_ready;
    assign ready_term = ~active | taken | out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            taken <= 1'b0;
        end else if (accept) begin
            taken <= 1'b0;
        end else if (served) begin
            taken <= 1'b1;
        end
    end

endmodule

// File: rtl/fanout_fork_ctrl.sv
// rtl/fanout_fork_ctrl.sv - eager fork handshake controller with shadowed config and debug counters
module fanout_fork_ctrl
    import fanout_pkg::*;
#(
    parameter int NUM_OUT = NUM_OUT_DEF,
    parameter int SEL_W   = SEL_W_DEF,
    parameter int SEL_BIT = SEL_BIT_DEF,
    parameter int CNT_W   = CNT_W_DEF
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_load,
    input  logic [NUM_OUT-1:0]       cfg_en,
    input  logic [NUM_OUT*SEL_W-1:0] cfg_sel,
    output logic                     cfg_busy,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_OUT-1:0]       out_valid,
    input  logic [NUM_OUT-1:0]       out_ready,
    output logic [CNT_W-1:0]         tok_cnt,
    output logic [CNT_W-1:0]         stall_cnt,
    input  logic                     cnt_clr
);

    state_t                   state;
    logic [NUM_OUT-1:0]       en_q;
    logic [NUM_OUT*SEL_W-1:0] sel_q;
    logic [NUM_OUT-1:0]       pend_en;
    logic [NUM_OUT*SEL_W-1:0] pend_sel;
    logic [NUM_OUT-1:0]       active;
    logic [NUM_OUT-1:0]       served;
    logic [NUM_OUT-1:0]       ready_term;
    logic                     accept;
    logic                     deliver;
    logic                     unused_sel;

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_branch
        assign active[i] = sel_active(en_q[i], sel_q[i*SEL_W + SEL_BIT]);

        fanout_branch u_branch (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_valid   (in_valid),
            .active     (active[i]),
            .out_ready  (out_ready[i]),
            .accept     (accept),
            .out_valid  (out_valid[i]),
            .served     (served[i]),
            .ready_term (ready_term[i])
        );
    end

    // Only one bit of each select field steers the fork; the rest is kept for readback.
    assign unused_sel = ^sel_q;

    assign in_ready = &ready_term;
    assign accept   = in_valid & in_ready;
    assign deliver  = |served;

    // Configuration may only change between tokens so taken bits stay coherent.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            en_q     <= '0;
            sel_q    <= '0;
            pend_en  <= '0;
            pend_sel <= '0;
            cfg_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_load) begin
                        en_q  <= cfg_en;
                        sel_q <= cfg_sel;
                    end
                    if (deliver && !accept) begin
                        state <= PARTIAL;
                    end
                end
                PARTIAL: begin
                    if (accept) begin
                        if (cfg_load) begin
                            en_q  <= cfg_en;
                            sel_q <= cfg_sel;
                        end
                        state <= IDLE;
                    end else if (cfg_load) begin
                        pend_en  <= cfg_en;
                        pend_sel <= cfg_sel;
                        cfg_busy <= 1'b1;
                        state    <= CFG_WAIT;
                    end
                end
                CFG_WAIT: begin
                    if (accept) begin
                        en_q     <= cfg_load ? cfg_en  : pend_en;
                        sel_q    <= cfg_load ? cfg_sel : pend_sel;
                        cfg_busy <= 1'b0;
                        state    <= IDLE;
                    end else if (cfg_load) begin
                        pend_en  <= cfg_en;
                        pend_sel <= cfg_sel;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cfg_busy <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            tok_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (accept) begin
                tok_cnt <= tok_cnt + CNT_W'(1);
            end
            if (in_valid && !in_ready && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fanout_fork_ctrl.sv
// tb/tb_fanout_fork_ctrl.sv - directed self-checking bench for fanout_fork_ctrl
module tb_fanout_fork_ctrl;

    localparam int NUM_OUT = 20;
    localparam int SEL_W   = 8;
    localparam int CNT_W   = 16;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     cfg_load;
    logic [NUM_OUT-1:0]       cfg_en;
    logic [NUM_OUT*SEL_W-1:0] cfg_sel;
    logic                     cfg_busy;
    logic                     in_valid;
    logic                     in_ready;
    logic [NUM_OUT-1:0]       out_valid;
    logic [NUM_OUT-1:0]       out_ready;
    logic [CNT_W-1:0]         tok_cnt;
    logic [CNT_W-1:0]         stall_cnt;
    logic                     cnt_clr;

    int pass_cnt = 0;
    int check_cnt = 0;

    fanout_fork_ctrl #(
        .NUM_OUT (NUM_OUT),
        .SEL_W   (SEL_W),
        .SEL_BIT (6),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_load  (cfg_load),
        .cfg_en    (cfg_en),
        .cfg_sel   (cfg_sel),
        .cfg_busy  (cfg_busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tok_cnt   (tok_cnt),
        .stall_cnt (stall_cnt),
        .cnt_clr   (cnt_clr)
    );

    always #5 clk = ~clk;

    // Producer must hold in_valid once any branch has taken the token.
    logic mid_token;
    always @(posedge clk) begin
        if (!rst_n) begin
            mid_token <= 1'b0;
        end else begin
            assert (!(mid_token && !in_valid)) else $error("protocol: in_valid dropped mid-token");
            if (in_valid && in_ready) mid_token <= 1'b0;
            else if (|(out_valid & out_ready)) mid_token <= 1'b1;
        end
    end

    function automatic logic [NUM_OUT*SEL_W-1:0] sel_for(input logic [NUM_OUT-1:0] mask);
        logic [NUM_OUT*SEL_W-1:0] s;
        s = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (mask[i]) s[i*SEL_W + 6] = 1'b1;
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic load_cfg(input logic [NUM_OUT-1:0] en, input logic [NUM_OUT-1:0] selmask);
        cfg_load = 1'b1;
        cfg_en   = en;
        cfg_sel  = sel_for(selmask);
        tick();
        cfg_load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        settle();
        check_cnt++; if (out_valid !== 20'h0) $display("FAIL reset_out_valid: got %h expected %h", out_valid, 20'h0); else pass_cnt++;
        check_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else pass_cnt++;
        check_cnt++; if (cfg_busy !== 1'b0) $display("FAIL reset_cfg_busy: got %b expected 0", cfg_busy); else pass_cnt++;
        check_cnt++; if (tok_cnt !== 16'h0) $display("FAIL reset_tok_cnt: got %h expected 0", tok_cnt); else pass_cnt++;
        check_cnt++; if (stall_cnt !== 16'h0) $display("FAIL reset_stall_cnt: got %h expected 0", stall_cnt); else pass_cnt++;
    endtask

    task automatic test_all_ready();
        load_cfg(20'h00003, 20'h00003);
        in_valid  = 1'b1;
        out_ready = '1;
        settle();
        check_cnt++; if (out_valid !== 20'h00003) $display("FAIL all_ready_out_valid: got %h expected 00003", out_valid); else pass_cnt++;
        check_cnt++; if (in_ready !== 1'b1) $display("FAIL all_ready_in_ready: got %b expected 1", in_ready); else pass_cnt++;
        tick();
        in_valid = 1'b0;
        settle();
        check_cnt++; if (tok_cnt !== 16'd1) $display("FAIL all_ready_tok_cnt: got %0d expected 1", tok_cnt); else pass_cnt++;
    endtask

    task automatic test_partial();
        in_valid  = 1'b1;
        out_ready = 20'h00001;
        settle();
        check_cnt++; if (in_ready !== 1'b0) $display("FAIL partial_c1_in_ready: got %b expected 0", in_ready); else pass_cnt++;
        tick();
        out_ready = 20'h00002;
        settle();
        check_cnt++; if (out_valid !== 20'h00002) $display("FAIL partial_c2_out_valid: got %h expected 00002", out_valid); else pass_cnt++;
        check_cnt++; if (in_ready !== 1'b1) $display("FAIL partial_c2_in_ready: got %b expected 1", in_ready); else pass_cnt++;
        tick();
        in_valid  = 1'b0;
        out_ready = '0;
        settle();
        check_cnt++; if (stall_cnt !== 16'd1) $display("FAIL partial_stall_cnt: got %0d expected 1", stall_cnt); else pass_cnt++;
        check_cnt++; if (tok_cnt !== 16'd2) $display("FAIL partial_tok_cnt: got %0d expected 2", tok_cnt); else pass_cnt++;
    endtask

    task automatic test_drop();
        load_cfg(20'h00001, 20'h00000);
        in_valid  = 1'b1;
        out_ready = '0;
        settle();
        check_cnt++; if (out_valid !== 20'h0) $display("FAIL drop_out_valid: got %h expected 00000", out_valid); else pass_cnt++;
        check_cnt++; if (in_ready !== 1'b1) $display("FAIL drop_in_ready: got %b expected 1", in_ready); else pass_cnt++;
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        settle();
        check_cnt++; if (tok_cnt !== 16'd5) $display("FAIL drop_tok_cnt: got %0d expected 5", tok_cnt); else pass_cnt++;
        check_cnt++; if (stall_cnt !== 16'd1) $display("FAIL drop_stall_cnt: got %0d expected 1", stall_cnt); else pass_cnt++;
    endtask

    task automatic test_cfg_partial();
        load_cfg(20'h00003, 20'h00003);
        in_valid  = 1'b1;
        out_ready = 20'h00001;
        tick();
        out_ready = '0;
        load_cfg(20'h00007, 20'h00007);
        settle();
        check_cnt++; if (cfg_busy !== 1'b1) $display("FAIL cfgp_busy_set: got %b expected 1", cfg_busy); else pass_cnt++;
        check_cnt++; if (out_valid !== 20'h00002) $display("FAIL cfgp_old_cfg_valid: got %h expected 00002", out_valid); else pass_cnt++;
        out_ready = 20'h00002;
        settle();
        check_cnt++; if (in_ready !== 1'b1) $display("FAIL cfgp_in_ready: got %b expected 1", in_ready); else pass_cnt++;
        tick();
        out_ready = '0;
        settle();
        check_cnt++; if (cfg_busy !== 1'b0) $display("FAIL cfgp_busy_clear: got %b expected 0", cfg_busy); else pass_cnt++;
        check_cnt++; if (out_valid !== 20'h00007) $display("FAIL cfgp_new_cfg_valid: got %h expected 00007", out_valid); else pass_cnt++;
        out_ready = 20'h00007;
        tick();
        in_valid  = 1'b0;
        out_ready = '0;
        settle();
        check_cnt++; if (tok_cnt !== 16'd7) $display("FAIL cfgp_tok_cnt: got %0d expected 7", tok_cnt); else pass_cnt++;
    endtask

    task automatic test_stall_saturate();
        in_valid  = 1'b1;
        out_ready = '0;
        for (int n = 0; n < 70000; n++) begin
            @(posedge clk);
        end
        #1;
        check_cnt++; if (stall_cnt !== 16'hFFFF) $display("FAIL stall_saturate: got %h expected ffff", stall_cnt); else pass_cnt++;
        check_cnt++; if (tok_cnt !== 16'd7) $display("FAIL stall_tok_hold: got %0d expected 7", tok_cnt); else pass_cnt++;
        cnt_clr = 1'b1;
        tick();
        cnt_clr  = 1'b0;
        in_valid = 1'b0;
        settle();
        check_cnt++; if (stall_cnt !== 16'h0) $display("FAIL clr_stall_cnt: got %h expected 0", stall_cnt); else pass_cnt++;
        check_cnt++; if (tok_cnt !== 16'h0) $display("FAIL clr_tok_cnt: got %h expected 0", tok_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_mid_token();
        load_cfg(20'h00003, 20'h00003);
        in_valid  = 1'b1;
        out_ready = 20'h00001;
        tick();
        in_valid  = 1'b0;
        out_ready = '0;
        rst_n     = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        check_cnt++; if (out_valid !== 20'h0) $display("FAIL rstmid_out_valid: got %h expected 00000", out_valid); else pass_cnt++;
        check_cnt++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); else pass_cnt++;
        check_cnt++; if (cfg_busy !== 1'b0) $display("FAIL rstmid_cfg_busy: got %b expected 0", cfg_busy); else pass_cnt++;
        load_cfg(20'h00003, 20'h00003);
        in_valid = 1'b1;
        settle();
        check_cnt++; if (out_valid !== 20'h00003) $display("FAIL rstmid_redeliver: got %h expected 00003", out_valid); else pass_cnt++;
        out_ready = 20'h00003;
        tick();
        in_valid  = 1'b0;
        out_ready = '0;
        settle();
        check_cnt++; if (tok_cnt !== 16'd1) $display("FAIL rstmid_tok_cnt: got %0d expected 1", tok_cnt); else pass_cnt++;
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_load  = 1'b0;
        cfg_en    = '0;
        cfg_sel   = '0;
        in_valid  = 1'b0;
        out_ready = '0;
        cnt_clr   = 1'b0;
        test_reset();
        test_all_ready();
        test_partial();
        test_drop();
        test_cfg_partial();
        test_stall_saturate();
        test_reset_mid_token();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
